// File: rtl/demux183_hs_pkg.sv
// Shared definitions for the demux183_hs write-side demultiplexer: widths,
// FSM state encoding and register write-back channel names.
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif

package demux183_hs_pkg;

    localparam int SEL_WIDTH = 3;
    localparam int NUM_CH    = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Destination names when the block drives CPU register write-back.
    typedef enum logic [SEL_WIDTH-1:0] {
        CH_A   = 3'd0,
        CH_X   = 3'd1,
        CH_Y   = 3'd2,
        CH_SP  = 3'd3,
        CH_P   = 3'd4,
        CH_PCL = 3'd5,
        CH_PCH = 3'd6,
        CH_BUS = 3'd7
    } ch_t;

endpackage

// File: rtl/demux183_hs_dec.sv
// Combinational 3-bit to one-hot-8 decoder; drives both the per-channel
// write enables and the value loaded into out_valid.
import demux183_hs_pkg::*;

module dec_3to8 (
    input  logic [SEL_WIDTH-1:0] sel,
    output logic [NUM_CH-1:0]    onehot
);

    assign onehot = NUM_CH'(1) << sel;

endmodule

// File: rtl/demux183_hs.sv
// Registered 1-to-8 demultiplexer with valid/ready handshake and a
// programmable hold timeout that drops an unaccepted transfer.
import demux183_hs_pkg::*;

module demux183_hs #(
    parameter int SIGNAL_WIDTH  = `REG_WIDTH,
    parameter int TIMEOUT       = 15,
    parameter int TIMEOUT_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SIGNAL_WIDTH-1:0] in_data,
    input  logic [SEL_WIDTH-1:0]    in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [SIGNAL_WIDTH-1:0] out0,
    output logic [SIGNAL_WIDTH-1:0] out1,
    output logic [SIGNAL_WIDTH-1:0] out2,
    output logic [SIGNAL_WIDTH-1:0] out3,
    output logic [SIGNAL_WIDTH-1:0] out4,
    output logic [SIGNAL_WIDTH-1:0] out5,
    output logic [SIGNAL_WIDTH-1:0] out6,
    output logic [SIGNAL_WIDTH-1:0] out7,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic                    busy,
    output logic                    drop
);

    localparam bit TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST =
        TIMEOUT_EN ? TIMEOUT_WIDTH'(TIMEOUT - 1) : '0;

    state_t                   state;
    logic [SEL_WIDTH-1:0]     sel_q;
    logic [TIMEOUT_WIDTH-1:0] cnt;
    logic [SIGNAL_WIDTH-1:0]  data_q [NUM_CH];
    logic [NUM_CH-1:0]        sel_onehot;
    logic                     accept;
    logic                     ready_hit;

    dec_3to8 u_dec (
        .sel    (in_sel),
        .onehot (sel_onehot)
    );

    // in_ready depends only on registered state and reset, never on in_valid.
    assign in_ready  = rst_n & (state == ST_IDLE);
    assign busy      = (state == ST_HOLD);
    assign accept    = in_valid & (state == ST_IDLE);
    assign ready_hit = out_ready[sel_q];

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; blocking would make ordering leak into logic.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sel_q     <= '0;
            cnt       <= '0;
            out_valid <= '0;
            drop      <= 1'b0;
            // NOTE: the channel registers are a reset-cleared register file,
            // not a RAM, so clearing them here is intended and cheap.
            for (int k = 0; k < NUM_CH; k++) data_q[k] <= '0;
        end else begin
            drop <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        for (int k = 0; k < NUM_CH; k++)
                            if (sel_onehot[k]) data_q[k] <= in_data;
                        out_valid <= sel_onehot;
                        sel_q     <= in_sel;
                        cnt       <= '0;
                        state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // A ready on the selected sink wins over a coincident timeout.
                    if (ready_hit) begin
                        out_valid <= '0;
                        state     <= ST_IDLE;
                    end else if (TIMEOUT_EN && cnt == CNT_LAST) begin
                        out_valid <= '0;
                        drop      <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (TIMEOUT_EN) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign out0 = data_q[0];
    assign out1 = data_q[1];
    assign out2 = data_q[2];
    assign out3 = data_q[3];
    assign out4 = data_q[4];
    assign out5 = data_q[5];
    assign out6 = data_q[6];
    assign out7 = data_q[7];

endmodule

// File: tb/tb_demux183_hs.sv
// Self-checking bench for demux183_hs (TIMEOUT=4): scoreboard of accepted
// transfers checked when out_valid rises, plus directed protocol checks.
import demux183_hs_pkg::*;

module tb_demux183_hs;

    localparam int W  = 8;
    localparam int TO = 4;

    typedef struct {
        int          ch;
        logic [W-1:0] data;
    } xfer_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [W-1:0]     in_data;
    logic [2:0]       in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     out0, out1, out2, out3, out4, out5, out6, out7;
    logic [7:0]       out_valid;
    logic [7:0]       out_ready;
    logic             busy;
    logic             drop;

    int               n_cmp  = 0;
    int               n_fail = 0;
    xfer_t            sb_q[$];
    logic [W-1:0]     model_regs [8];
    logic [7:0]       prev_valid = '0;

    demux183_hs #(.SIGNAL_WIDTH(W), .TIMEOUT(TO), .TIMEOUT_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .out4(out4), .out5(out5), .out6(out6), .out7(out7),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .drop(drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] out_of(int k);
        case (k)
            0: return out0;
            1: return out1;
            2: return out2;
            3: return out3;
            4: return out4;
            5: return out5;
            6: return out6;
            default: return out7;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        for (int k = 0; k < 8; k++)
            check($sformatf("%s_out%0d", tag, k), out_of(k), model_regs[k]);
    endtask

    // Scoreboard: a new transfer shows as out_valid rising from zero.
    always @(posedge clk) begin
        #1;
        if (out_valid != 0 && prev_valid == 0) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_valid", out_valid, 8'h00);
            end else begin
                xfer_t e;
                e = sb_q.pop_front();
                check("sb_valid", out_valid, 8'(1) << e.ch);
                check("sb_data", out_of(e.ch), e.data);
            end
        end
        prev_valid = out_valid;
    end

    // Offer one word while idle; returns just after the accepting edge.
    task automatic send(input int ch, input logic [W-1:0] d);
        xfer_t e;
        check($sformatf("ready_before_ch%0d", ch), in_ready, 1'b1);
        in_valid = 1'b1;
        in_sel   = 3'(ch);
        in_data  = d;
        e.ch = ch;
        e.data = d;
        sb_q.push_back(e);
        model_regs[ch] = d;
        tick();
        in_valid = 1'b0;
        in_data  = 8'hFF;
        check($sformatf("busy_after_accept_ch%0d", ch), busy, 1'b1);
        check($sformatf("ready_low_hold_ch%0d", ch), in_ready, 1'b0);
    endtask

    task automatic release_ch(input int ch);
        out_ready = 8'(1) << ch;
        tick();
        out_ready = '0;
        check($sformatf("valid_clear_ch%0d", ch), out_valid, 8'h00);
        check($sformatf("ready_back_ch%0d", ch), in_ready, 1'b1);
        check($sformatf("no_drop_ch%0d", ch), drop, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
        for (int k = 0; k < 8; k++) model_regs[k] = '0;

        // Reset state
        tick(); tick();
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_valid", out_valid, 8'h00);
        check("rst_drop", drop, 1'b0);
        check("rst_busy", busy, 1'b0);
        check_regs("rst");
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", in_ready, 1'b1);

        // Basic transfer to channel 2
        send(int'(CH_Y), 8'hA5);
        check("t1_out2", out2, 8'hA5);
        check("t1_valid", out_valid, 8'b0000_0100);
        release_ch(int'(CH_Y));

        // Two back-to-back writes: earlier channel keeps its data
        send(int'(CH_SP), 8'h11);
        release_ch(int'(CH_SP));
        send(int'(CH_PCL), 8'h22);
        release_ch(int'(CH_PCL));
        check("t2_out3_kept", out3, 8'h11);
        check_regs("t2");

        // Timeout after TO hold cycles, data retained
        send(int'(CH_BUS), 8'h3C);
        for (int i = 0; i < TO; i++) begin
            check($sformatf("t3_valid_c%0d", i), out_valid, 8'h80);
            check($sformatf("t3_nodrop_c%0d", i), drop, 1'b0);
            tick();
        end
        check("t3_drop", drop, 1'b1);
        check("t3_busy", busy, 1'b0);
        check("t3_valid", out_valid, 8'h00);
        check("t3_out7", out7, 8'h3C);
        tick();
        check("t3_drop_pulse_end", drop, 1'b0);
        check("t3_ready", in_ready, 1'b1);

        // Ready in the same cycle as the timeout: ready wins
        send(int'(CH_BUS), 8'h5A);
        for (int i = 0; i < TO - 1; i++) tick();
        check("t4_still_valid", out_valid, 8'h80);
        out_ready = 8'h80;
        tick();
        out_ready = '0;
        check("t4_no_drop", drop, 1'b0);
        check("t4_valid", out_valid, 8'h00);
        check("t4_busy", busy, 1'b0);
        tick();
        check("t4_no_drop_late", drop, 1'b0);

        // Other ready bits cannot complete; input changes during HOLD ignored
        send(int'(CH_X), 8'h77);
        out_ready = 8'b1111_1101;
        in_valid  = 1'b1;
        for (int i = 0; i < TO - 1; i++) begin
            in_sel  = 3'(6 - i);
            in_data = 8'hE0 + 8'(i);
            tick();
            check($sformatf("t5_pending_c%0d", i), out_valid, 8'h02);
            check($sformatf("t5_out1_c%0d", i), out1, 8'h77);
        end
        in_valid  = 1'b0;
        check_regs("t5");
        out_ready = 8'b0000_0010;
        tick();
        out_ready = '0;
        check("t5_done_valid", out_valid, 8'h00);
        check("t5_done_drop", drop, 1'b0);
        check("t5_done_ready", in_ready, 1'b1);

        // Reset mid-HOLD aborts and clears everything
        send(int'(CH_P), 8'hC3);
        rst_n = 1'b0;
        #1;
        check("t6_ready_in_rst", in_ready, 1'b0);
        tick();
        for (int k = 0; k < 8; k++) model_regs[k] = '0;
        check_regs("t6");
        check("t6_valid", out_valid, 8'h00);
        check("t6_drop", drop, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_ready_low", in_ready, 1'b0);
        rst_n = 1'b1;
        #1;
        check("t6_ready_after", in_ready, 1'b1);
        tick();
        check("t6_no_drop_after", drop, 1'b0);

        // Post-reset sanity transfer
        send(int'(CH_A), 8'h5C);
        release_ch(int'(CH_A));
        check_regs("t7");

        tick();
        check("sb_queue_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/demux183_hs.md
Name: demux183_hs

Overview:
- Registered 1-to-8 demultiplexer with a valid/ready handshake; the write-side counterpart of the 8-to-1 read mux (mux831).
- Steers one source word to one of eight destination channels, for example CPU register write-back (A, X, Y, SP, P, PCL, PCH, bus latch).
- Each channel's data register keeps its last written value, so unselected destinations see stable data.
- The block holds a transfer until the selected sink accepts it, or until a programmable timeout expires and the transfer is dropped.

Parameters:
- SIGNAL_WIDTH, default `REG_WIDTH (8): width of the data path.
- TIMEOUT, default 15: maximum number of HOLD cycles before the transfer is dropped; 0 disables the timeout.
- TIMEOUT_WIDTH, default 4: width of the wait counter; must satisfy TIMEOUT <= 2^TIMEOUT_WIDTH - 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_data  in  SIGNAL_WIDTH  source word.
- in_sel  in  3  destination index; ignored while in_valid=0.
- in_valid  in  1  source offers a word.
- in_ready  out  1  block accepts a word this cycle.
- out0..out7  out  SIGNAL_WIDTH each  per-channel data registers.
- out_valid  out  8  one-hot; bit k qualifies outk.
- out_ready  in  8  bit k means sink k accepts.
- busy  out  1  a transfer is pending (state HOLD).
- drop  out  1  one-cycle pulse when a transfer times out.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; out0..out7=0; out_valid=0; drop=0; wait counter=0.
  - in_ready is forced to 0 while rst_n=0.
- in_ready = rst_n & (state==IDLE). This is combinational from registered state only; there is no path from in_valid to in_ready.
- State IDLE:
  - Accept when in_valid & in_ready.
  - On the next edge: out[in_sel] <= in_data; out_valid <= onehot(in_sel); captured selector stored; counter <= 0; state <= HOLD.
  - Latency from accept to out_valid is exactly 1 cycle.
- State HOLD (busy=1, in_ready=0):
  - If out_ready[sel]=1: out_valid <= 0; state <= IDLE.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: out_valid <= 0; drop <= 1 for one cycle; state <= IDLE. The data register keeps the dropped word.
  - Else: counter <= counter+1.
- Peak throughput is one transfer per 2 cycles. There is no same-cycle accept-on-release.
- Only out_ready[sel] is examined. Ready bits of other channels are ignored and cannot complete the transfer.
- If out_ready[sel] and the timeout condition occur in the same cycle, ready wins: no drop, normal completion.
- Unselected channels' data and valid bits never change.
- Changes to in_data or in_sel during HOLD have no effect.
- A valid bit is never asserted in the cycle after the release of an earlier transfer unless a new accept occurred.
- rst_n=0 mid-HOLD aborts the transfer: valid clears, drop is not pulsed, and all data registers clear.
- The counter never wraps. It is bounded by TIMEOUT-1. With TIMEOUT=0 the counter is frozen at 0 and HOLD waits indefinitely.
- drop is registered and is 0 in every cycle except the one following the timeout edge.

Decomposition:
- Shared package/header:
  - `REG_WIDTH (8).
  - SEL_WIDTH=3 and NUM_CH=8.
  - State encodings ST_IDLE=1'b0 and ST_HOLD=1'b1.
  - Channel index names for register write-back (e.g. CH_A=0, CH_X=1, CH_Y=2, CH_SP=3, CH_P=4, CH_PCL=5, CH_PCH=6, CH_BUS=7).
- One natural sub-module: dec_3to8, a combinational 3-bit to one-hot 8 decoder. It is reused for out_valid and for the per-channel write enables.

Test Plan:
- Reset, then in_valid=1, in_sel=2, in_data=8'hA5 → accepted on the first cycle. Next cycle: out2=8'hA5, out_valid=8'b0000_0100, busy=1, in_ready=0. out_ready[2]=1 → out_valid=0 next cycle, in_ready=1.
- Write ch3=8'h11, then ch5=8'h22, both released immediately → out3 stays 8'h11 after the ch5 write. out_valid returns to 0 after each transfer.
- TIMEOUT=4, write ch7=8'h3C, out_ready=0 → out_valid[7] high for 4 cycles, then drop=1 for exactly one cycle, busy=0, out7 still 8'h3C.
- TIMEOUT=4, out_ready[7] asserted in the 4th HOLD cycle, same cycle as the timeout → normal completion, drop stays 0.
- Pending on ch1, out_ready=8'b1111_1101 (every bit except ch1) → transfer stays pending. in_data/in_sel changes during HOLD leave out1 unchanged. Set out_ready[1]=1 → completes.
- Reset asserted mid-HOLD on ch4 → next cycle all outk=0, out_valid=0, drop=0, in_ready=0 while rst_n=0. in_ready=1 in the first cycle after release.
